// File: rtl/coin_ctrl_pkg.sv
// Shared types and widths for the coin-input conditioner.
// Holds the FSM state encoding and the pending-queue saturation helper.
package coin_ctrl_pkg;

    typedef enum logic [1:0] {
        CS_IDLE  = 2'd0,
        CS_PULSE = 2'd1,
        CS_GAP   = 2'd2
    } coin_state_t;

    localparam int PEND_W  = 4;
    localparam int FCNT_W  = 4;
    localparam int TOTAL_W = 16;

    // Clamp a one-bit-wider queue sum to the configured ceiling.
    function automatic logic [PEND_W-1:0] pend_sat(input logic [PEND_W:0] sum,
                                                   input logic [PEND_W:0] max_v);
        logic [PEND_W:0] v;
        v = (sum > max_v) ? max_v : sum;
        return v[PEND_W-1:0];
    endfunction

endpackage

// File: rtl/coin_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, run-length debounce and a one-cycle
// rising-edge pulse of the debounced level. Reusable for start buttons.
module btn_debounce #(
    parameter int DEB_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_btn,
    output logic o_rise
);

    localparam int CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_deb;
    logic             r_deb_q;
    logic [CNT_W-1:0] r_cnt;

    // The level only flips after DEB_CYCLES consecutive disagreeing samples,
    // so press and release bounce are both absorbed by the same counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_q <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_btn;
            r_s2    <= r_s1;
            r_deb_q <= r_deb;
            if (r_s2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_deb <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_rise = r_deb & ~r_deb_q;

endmodule

// File: rtl/coin_ctrl.sv
// Coin conditioner feeding the game's coin input: queues debounced presses and
// replays each as a vblank-timed pulse followed by a forced low gap.
module coin_ctrl
    import coin_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES   = 4096,
    parameter int PULSE_FRAMES = 3,
    parameter int GAP_FRAMES   = 3,
    parameter int QUEUE_MAX    = 7
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 vblank,
    input  logic                 coin_btn,
    output logic                 coin_out,
    output logic                 busy,
    output logic [PEND_W-1:0]    pending,
    output logic [TOTAL_W-1:0]   coin_total,
    output logic [1:0]           state_dbg
);

    localparam logic [FCNT_W-1:0] PULSE_LAST = FCNT_W'(PULSE_FRAMES - 1);
    localparam logic [FCNT_W-1:0] GAP_LAST   = FCNT_W'(GAP_FRAMES - 1);
    localparam logic [PEND_W:0]   QMAX       = (PEND_W + 1)'(QUEUE_MAX);

    coin_state_t         r_state;
    coin_state_t         w_state_nxt;
    logic [FCNT_W-1:0]   r_fcnt;
    logic [FCNT_W-1:0]   w_fcnt_nxt;
    logic [PEND_W-1:0]   r_pending;
    logic [PEND_W-1:0]   w_pending_nxt;
    logic [PEND_W:0]     w_pend_sum;
    logic [TOTAL_W-1:0]  r_total;
    logic                r_coin_out;
    logic                w_coin_out_nxt;
    logic                r_vblank_q;
    logic                w_press;
    logic                w_inc;
    logic                w_dec;
    logic                w_tick;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .i_btn   (coin_btn),
        .o_rise  (w_press)
    );

    assign w_inc  = w_press & enable;
    assign w_tick = vblank & ~r_vblank_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= CS_IDLE;
            r_fcnt     <= '0;
            r_pending  <= '0;
            r_coin_out <= 1'b0;
            r_vblank_q <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fcnt     <= w_fcnt_nxt;
            r_pending  <= w_pending_nxt;
            r_coin_out <= w_coin_out_nxt;
            r_vblank_q <= vblank;
        end
    end

    // Every accepted press counts, even one dropped by a full queue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_total <= '0;
        end else if (w_inc) begin
            r_total <= r_total + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fcnt_nxt     = r_fcnt;
        w_coin_out_nxt = r_coin_out;
        w_dec          = 1'b0;
        w_pend_sum     = '0;
        w_pending_nxt  = r_pending;

        if (!enable) begin
            w_state_nxt    = CS_IDLE;
            w_fcnt_nxt     = '0;
            w_coin_out_nxt = 1'b0;
        end else begin
            unique case (r_state)
                CS_IDLE: begin
                    // A press arriving while idle is dequeued in the same cycle.
                    if ((r_pending != '0) || w_inc) begin
                        w_dec          = 1'b1;
                        w_state_nxt    = CS_PULSE;
                        w_fcnt_nxt     = '0;
                        w_coin_out_nxt = 1'b1;
                    end
                end
                CS_PULSE: begin
                    if (w_tick) begin
                        if (r_fcnt == PULSE_LAST) begin
                            w_state_nxt    = CS_GAP;
                            w_fcnt_nxt     = '0;
                            w_coin_out_nxt = 1'b0;
                        end else begin
                            w_fcnt_nxt = r_fcnt + 1'b1;
                        end
                    end
                end
                CS_GAP: begin
                    if (w_tick) begin
                        if (r_fcnt == GAP_LAST) begin
                            w_state_nxt = CS_IDLE;
                            w_fcnt_nxt  = '0;
                        end else begin
                            w_fcnt_nxt = r_fcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt    = CS_IDLE;
                    w_fcnt_nxt     = '0;
                    w_coin_out_nxt = 1'b0;
                end
            endcase
        end

        w_pend_sum = {1'b0, r_pending} + {{PEND_W{1'b0}}, w_inc}
                   - {{PEND_W{1'b0}}, w_dec};
        if (!enable) begin
            w_pending_nxt = '0;
        end else begin
            w_pending_nxt = pend_sat(w_pend_sum, QMAX);
        end
    end

    assign coin_out   = r_coin_out;
    assign busy       = (r_state != CS_IDLE);
    assign pending    = r_pending;
    assign coin_total = r_total;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_coin_ctrl.sv
// Randomized and directed bench for coin_ctrl: a reference model predicts each
// coin pulse (start/end cycle) plus queue and total values every cycle.
module tb_coin_ctrl;

    localparam int DEB = 8;
    localparam int PF  = 3;
    localparam int GF  = 3;
    localparam int QM  = 7;
    localparam int VBP = 100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        vblank;
    logic        coin_btn;
    logic        coin_out;
    logic        busy;
    logic [3:0]  pending;
    logic [15:0] coin_total;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [39:0] exp_q[$];

    coin_ctrl #(
        .DEB_CYCLES   (DEB),
        .PULSE_FRAMES (PF),
        .GAP_FRAMES   (GF),
        .QUEUE_MAX    (QM)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .vblank     (vblank),
        .coin_btn   (coin_btn),
        .coin_out   (coin_out),
        .busy       (busy),
        .pending    (pending),
        .coin_total (coin_total),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: mode 0 = idle, 1 = coin high, 2 = forced low gap.
    logic        m_s1, m_s2, m_deb, m_rose, m_vb;
    int          m_run, m_mode, m_ticks, m_pend, m_start;
    logic [15:0] m_total;

    always @(posedge clk) begin
        bit inc, tick, dec;
        cyc++;
        if (!reset_n) begin
            m_s1 = 0; m_s2 = 0; m_deb = 0; m_rose = 0; m_vb = 0;
            m_run = 0; m_mode = 0; m_ticks = 0; m_pend = 0; m_start = 0;
            m_total = 0;
        end else begin
            inc  = m_rose && enable;
            tick = vblank && !m_vb;
            dec  = 0;
            m_rose = 0;
            if (m_s2 != m_deb) begin
                m_run++;
                if (m_run == DEB) begin
                    m_deb  = m_s2;
                    m_run  = 0;
                    m_rose = m_deb;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = coin_btn;
            m_vb = vblank;
            if (!enable) begin
                if (m_mode == 1) exp_q.push_back({20'(m_start), 20'(cyc)});
                m_mode = 0; m_ticks = 0; m_pend = 0;
            end else begin
                if (inc) m_total++;
                if (m_mode == 0) begin
                    if (m_pend > 0 || inc) begin
                        dec = 1; m_mode = 1; m_ticks = 0; m_start = cyc;
                    end
                end else if (tick) begin
                    m_ticks++;
                    if (m_mode == 1 && m_ticks == PF) begin
                        exp_q.push_back({20'(m_start), 20'(cyc)});
                        m_mode = 2; m_ticks = 0;
                    end else if (m_mode == 2 && m_ticks == GF) begin
                        m_mode = 0; m_ticks = 0;
                    end
                end
                m_pend = m_pend + int'(inc) - int'(dec);
                if (m_pend > QM) m_pend = QM;
            end
        end
    end

    // Monitor: per-cycle state comparison and pulse scoreboard.
    logic        mon_prev = 1'b0;
    int          mon_rise = 0;
    int          pulse_cnt = 0;
    int          max_pend = 0;
    logic [39:0] got_rec;

    always @(posedge clk) begin
        #2;
        check("pending", pending, m_pend);
        check("coin_total", coin_total, m_total);
        check("busy", busy, m_mode != 0);
        check("coin_out", coin_out, m_mode == 1);
        if (int'(pending) > max_pend) max_pend = int'(pending);
        if (coin_out && !mon_prev) begin
            mon_rise = cyc;
            pulse_cnt++;
        end
        if (!coin_out && mon_prev) begin
            got_rec = {20'(mon_rise), 20'(cyc)};
            if (exp_q.size() == 0) check("pulse_unexpected", got_rec, 0);
            else check("pulse_span", got_rec, exp_q.pop_front());
        end
        mon_prev = coin_out;
    end

    logic vb_hold = 1'b0;
    initial begin
        vblank = 1'b0;
        forever begin
            @(negedge clk);
            vblank = vb_hold || ((cyc % VBP) < 20);
        end
    end

    int press_edge;
    task automatic press(input int hi, input int lo);
        @(negedge clk);
        coin_btn   = 1'b1;
        press_edge = cyc;
        repeat (hi) @(negedge clk);
        coin_btn = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(posedge clk); #2;
            if (!busy && pending == 0) break;
            n++;
        end
        check("idle_timeout", n < budget, 1);
    endtask

    int exp_total, pc0, n;

    initial begin
        reset_n = 1'b0; enable = 1'b1; coin_btn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_coin_out", coin_out, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_total", coin_total, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single press
        press(50, 20);
        wait_idle(1000);
        check("single_rise_edge", mon_rise, press_edge + DEB + 3);
        exp_total = 1;
        check("single_total", coin_total, exp_total);
        check("single_pending", pending, 0);

        // Glitch shorter than the debounce window
        pc0 = pulse_cnt;
        press(5, 30);
        check("glitch_total", coin_total, exp_total);
        check("glitch_pulses", pulse_cnt - pc0, 0);

        // Burst saturates the queue
        pc0 = pulse_cnt;
        max_pend = 0;
        for (int i = 0; i < 10; i++) press(20, 20);
        exp_total += 10;
        wait_idle(8000);
        check("burst_total", coin_total, exp_total);
        check("burst_pulses", pulse_cnt - pc0, 8);
        check("burst_max_pending", max_pend, QM);

        // vblank held high must not retick
        press(20, 20);
        exp_total++;
        vb_hold = 1'b1;
        repeat (300) @(negedge clk);
        vb_hold = 1'b0;
        wait_idle(1500);

        // Flush with pending=3 mid-pulse
        for (int i = 0; i < 4; i++) press(12, 12);
        exp_total += 4;
        check("flush_pre_out", coin_out, 1);
        check("flush_pre_pending", pending, 3);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #2;
        check("flush_out", coin_out, 0);
        check("flush_busy", busy, 0);
        check("flush_pending", pending, 0);
        press(20, 20);
        check("disabled_pending", pending, 0);
        check("disabled_total", coin_total, exp_total);
        enable = 1'b1;
        repeat (5) @(negedge clk);
        check("reenable_busy", busy, 0);

        // Reset during the gap
        press(20, 20);
        n = 0;
        while (n < 1000) begin
            @(posedge clk); #2;
            if (busy && !coin_out && pending == 0) break;
            n++;
        end
        check("gap_reached", n < 1000, 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_out", coin_out, 0);
        check("async_busy", busy, 0);
        check("async_total", coin_total, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        pc0 = pulse_cnt;
        press(20, 20);
        wait_idle(1000);
        check("post_reset_total", coin_total, 1);
        check("post_reset_pulses", pulse_cnt - pc0, 1);

        // Random presses with occasional disable windows
        for (int i = 0; i < 40; i++) begin
            press($urandom_range(2, 30), $urandom_range(2, 60));
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                enable = 1'b0;
                repeat ($urandom_range(5, 200)) @(negedge clk);
                enable = 1'b1;
            end
        end
        wait_idle(10000);
        repeat (5) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
